// File: rtl/jtbubl_gfx_romslot.sv
// Graphics ROM slot responder: serves 32-bit engine reads from a tagged buffer, filling misses
// with a burst-of-2 SDRAM read. Define JTBUBL_GFXROM_2WAY_EN for a two-entry LRU buffer.
module jtbubl_gfx_romslot #(
   parameter int unsigned         SDRAM_AW = 22,
   parameter logic [SDRAM_AW-1:0] OFFSET   = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                slot_cs,
   input  logic [17:0]         slot_addr,
   output logic                slot_ok,
   output logic [31:0]         slot_dout,
   output logic                sdram_req,
   output logic [SDRAM_AW-1:0] sdram_addr,
   input  logic                sdram_ack,
   input  logic                sdram_dst,
   input  logic [15:0]         data_read
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_DATA
   } state_t;

   state_t                r_state;
   state_t                w_state_nx;

   logic [16:0]           w_tag;
   logic                  w_unused_addr0;
   logic                  w_hit;
   logic                  w_latch;
   logic                  w_wr;
   logic                  w_fill;
   logic [SDRAM_AW-1:0]   w_req_base;

   logic [16:0]           r_req_tag;
   logic                  r_wcnt;
   logic [15:0]           r_fill_lo;

   logic                  r_valid0;
   logic [16:0]           r_tag0;
   logic [31:0]           r_data0;

   // Bit 0 selects a half of the 32-bit word, which is always fetched whole
   assign w_tag          = slot_addr[17:1];
   assign w_unused_addr0 = slot_addr[0];

   always_comb begin
      w_req_base       = '0;
      w_req_base[17:0] = {r_req_tag, 1'b0};
   end

   assign sdram_addr = OFFSET + w_req_base;

`ifdef JTBUBL_GFXROM_2WAY_EN
   logic                  r_valid1;
   logic [16:0]           r_tag1;
   logic [31:0]           r_data1;
   logic                  r_lru;
   logic                  r_last;
   logic                  w_m0;
   logic                  w_m1;
   logic                  w_hit_idx;

   assign w_m0      = r_valid0 && (r_tag0 == w_tag);
   assign w_m1      = r_valid1 && (r_tag1 == w_tag);
   assign w_hit     = slot_cs && (w_m0 || w_m1);
   assign w_hit_idx = !w_m0;
   assign slot_dout = w_hit ? (w_hit_idx ? r_data1 : r_data0)
                            : (r_last    ? r_data1 : r_data0);
`else
   assign w_hit     = slot_cs && r_valid0 && (r_tag0 == w_tag);
   assign slot_dout = r_data0;
`endif

   assign slot_ok = w_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_latch    = 1'b0;
      w_wr       = 1'b0;
      w_fill     = 1'b0;
      sdram_req  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (slot_cs && !w_hit) begin
               w_latch    = 1'b1;
               w_state_nx = ST_REQ;
            end
         end
         ST_REQ: begin
            sdram_req = 1'b1;
            // A strobe coinciding with the ack is the first word of the burst
            if (sdram_ack) begin
               w_wr       = sdram_dst;
               w_state_nx = ST_DATA;
            end
         end
         ST_DATA: begin
            if (sdram_dst) begin
               w_wr = 1'b1;
               if (r_wcnt) begin
                  w_fill     = 1'b1;
                  w_state_nx = ST_IDLE;
               end
            end
         end
         default: w_state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_req_tag <= '0;
         r_wcnt    <= 1'b0;
         r_fill_lo <= '0;
      end else begin
         if (w_latch) begin
            r_req_tag <= w_tag;
         end
         if (w_wr) begin
            r_wcnt <= ~r_wcnt;
            if (!r_wcnt) begin
               r_fill_lo <= data_read;
            end
         end
      end
   end

`ifdef JTBUBL_GFXROM_2WAY_EN
   // r_lru points at the victim; a fill takes priority over a concurrent hit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid0 <= 1'b0;
         r_tag0   <= '0;
         r_data0  <= '0;
         r_valid1 <= 1'b0;
         r_tag1   <= '0;
         r_data1  <= '0;
         r_lru    <= 1'b0;
         r_last   <= 1'b0;
      end else begin
         if (w_fill) begin
            if (!r_lru) begin
               r_valid0 <= 1'b1;
               r_tag0   <= r_req_tag;
               r_data0  <= {data_read, r_fill_lo};
            end else begin
               r_valid1 <= 1'b1;
               r_tag1   <= r_req_tag;
               r_data1  <= {data_read, r_fill_lo};
            end
            r_lru  <= ~r_lru;
            r_last <= r_lru;
         end else if (w_hit) begin
            r_lru <= ~w_hit_idx;
         end
      end
   end
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid0 <= 1'b0;
         r_tag0   <= '0;
         r_data0  <= '0;
      end else if (w_fill) begin
         r_valid0 <= 1'b1;
         r_tag0   <= r_req_tag;
         r_data0  <= {data_read, r_fill_lo};
      end
   end
`endif

endmodule
